fetch_prefetch_stage: RTL
=========================

FETCH_PREFETCH_STAGE -- requirements
Module: fetch_prefetch_stage

Interface
REQ-001 Parameter ADDR_WIDTH, 32, PC and memory address width.
REQ-002 Parameter INST_WIDTH, 32, instruction width.
REQ-003 Parameter FIFO_DEPTH, 4, prefetch queue entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, 0, first fetch address after reset.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 i_PCSrc_F  in  1  redirect request from execute.
REQ-009 i_PC_Target_F  in  ADDR_WIDTH  redirect target.
REQ-010 i_Ready_D  in  1  decode accepts the head instruction.
REQ-011 o_Mem_Req  out  1  instruction memory request.
REQ-012 o_Mem_Addr  out  ADDR_WIDTH  request address.
REQ-013 i_Mem_Gnt  in  1  request accepted this cycle.
REQ-014 i_Mem_Rvalid  in  1  in-order response valid.
REQ-015 i_Mem_Rdata  in  INST_WIDTH  response instruction.
REQ-016 o_Valid_F  out  1  head instruction valid.
REQ-017 o_Instr_F  out  INST_WIDTH  head instruction.
REQ-018 o_PC_F  out  ADDR_WIDTH  PC of head instruction.
REQ-019 o_PCPluse4_F  out  ADDR_WIDTH  o_PC_F + 4.

Function
REQ-020 State: issue_pc, rsp_pc, FIFO of {pc, instr}, count (0..FIFO_DEPTH), outstanding (0..FIFO_DEPTH), drop_cnt; counters clog2(FIFO_DEPTH)+1 bits.
REQ-021 o_Mem_Req = !i_PCSrc_F && (count + outstanding < FIFO_DEPTH); o_Mem_Addr = issue_pc.
REQ-022 Req && Gnt: issue_pc += 4 (wraps mod 2^ADDR_WIDTH), outstanding += 1.
REQ-023 Rvalid: outstanding -= 1; if drop_cnt != 0, discard and drop_cnt -= 1; else push {rsp_pc, Rdata}, rsp_pc += 4.
REQ-024 Simultaneous grant and response: outstanding unchanged.
REQ-025 Pushed entry visible on outputs the cycle after Rvalid (no bypass).
REQ-026 o_Valid_F = (count != 0) && !i_PCSrc_F; outputs show FIFO head.
REQ-027 Pop when o_Valid_F && i_Ready_D; simultaneous push and pop keeps count.
REQ-028 Credit rule guarantees no push when full; Rvalid with outstanding == 0 is illegal, ignored.
REQ-029 Redirect cycle: FIFO flushed, issue_pc and rsp_pc <= {target[ADDR_WIDTH-1:2], 2'b00}, drop_cnt <= outstanding - Rvalid; no request, no push, no pop.
REQ-030 Two-state FSM: RUN (drop_cnt == 0), FLUSH (drop_cnt != 0); RUN->FLUSH on redirect with stale responses outstanding; FLUSH->RUN when last stale response is dropped.
REQ-031 Requests continue in FLUSH under the credit rule; redirect during FLUSH reloads drop_cnt per REQ-029.
REQ-032 i_Ready_D low holds head outputs stable.

Reset
REQ-033 rst low: issue_pc = rsp_pc = RESET_PC, count = outstanding = drop_cnt = 0, FSM RUN, FIFO storage zeroed.
REQ-034 During reset: o_Mem_Req 0, o_Valid_F 0, o_Mem_Addr RESET_PC, o_Instr_F 0, o_PC_F 0, o_PCPluse4_F 4.
REQ-035 Reset mid-operation discards all in-flight responses without drop accounting; first request after release is RESET_PC.

Verification
REQ-036 Reset release, Gnt always 1, 1-cycle response, Ready 1 -> addresses 0,4,8,...; o_PC_F 0,4,8 in order; Instr matches memory.
REQ-037 Ready 0, DEPTH 4 -> after 4 grants o_Mem_Req 0, count 4; Ready 1 for one cycle -> one pop, one new request.
REQ-038 Three requests outstanding, redirect to 0x100 -> next request 0x100; three stale responses dropped; first o_PC_F 0x100.
REQ-039 Redirect target 0x103 -> fetch at 0x100.
REQ-040 Redirect coinciding with Rvalid and Ready -> no pop, no push, drop_cnt = outstanding - 1.
REQ-041 rst low mid-FLUSH -> all counters 0, o_Valid_F 0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_stage.sv
// Instruction prefetch stage. Keeps up to FIFO_DEPTH instructions either
// buffered or in flight toward a pipelined, in-order instruction memory.
// A redirect from execute flushes the buffer and drops the responses that
// are still in flight for the abandoned path.
module fetch_prefetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_PCSrc_F,
  input  logic [ADDR_WIDTH-1:0] i_PC_Target_F,
  input  logic                  i_Ready_D,
  output logic                  o_Mem_Req,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  input  logic                  i_Mem_Gnt,
  input  logic                  i_Mem_Rvalid,
  input  logic [INST_WIDTH-1:0] i_Mem_Rdata,
  output logic                  o_Valid_F,
  output logic [INST_WIDTH-1:0] o_Instr_F,
  output logic [ADDR_WIDTH-1:0] o_PC_F,
  output logic [ADDR_WIDTH-1:0] o_PCPluse4_F
);

  localparam int                    PW        = $clog2(FIFO_DEPTH);
  localparam int                    CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]           DEPTH_LIM = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MSK = ~(ADDR_WIDTH'(3));
  localparam logic [PW-1:0]         PTR_ONE   = PW'(1);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] issue_pc;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic [ADDR_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
  logic [INST_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         drop_cnt;

  logic [CW-1:0]         count_next;
  logic [CW-1:0]         outstanding_next;
  logic [CW-1:0]         drop_cnt_next;
  logic [CW:0]           credit_used;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  mem_req;
  logic                  gnt_fire;
  logic                  rsp_fire;
  logic                  rsp_drop;
  logic                  push;
  logic                  head_valid;
  logic                  pop;

  // A slot is reserved at request time, so buffered plus in-flight entries
  // can never exceed the buffer size and a response always finds room.
  assign credit_used = {1'b0, count} + {1'b0, outstanding};
  assign mem_req     = rst && !i_PCSrc_F && (credit_used < DEPTH_LIM);
  assign gnt_fire    = mem_req && i_Mem_Gnt;
  // A response with nothing outstanding is spurious and ignored.
  assign rsp_fire    = i_Mem_Rvalid && (outstanding != '0);
  assign rsp_drop    = rsp_fire && (state == FLUSH);
  assign push        = rsp_fire && (state == RUN) && !i_PCSrc_F;
  assign head_valid  = (count != '0) && !i_PCSrc_F;
  assign pop         = head_valid && i_Ready_D;
  assign redirect_pc = i_PC_Target_F & ALIGN_MSK;

  assign o_Mem_Req    = mem_req;
  assign o_Mem_Addr   = issue_pc;
  assign o_Valid_F    = head_valid;
  assign o_Instr_F    = instr_mem[rd_ptr];
  assign o_PC_F       = pc_mem[rd_ptr];
  assign o_PCPluse4_F = pc_mem[rd_ptr] + PC_STEP;

  // Next values of the occupancy, in-flight and stale-response counters.
  always_comb begin
    count_next       = count;
    outstanding_next = outstanding;
    drop_cnt_next    = drop_cnt;
    if (push && !pop)
      count_next = count + CNT_ONE;
    else if (!push && pop)
      count_next = count - CNT_ONE;
    if (gnt_fire && !rsp_fire)
      outstanding_next = outstanding + CNT_ONE;
    else if (!gnt_fire && rsp_fire)
      outstanding_next = outstanding - CNT_ONE;
    if (i_PCSrc_F) begin
      // Everything still in flight after this cycle belongs to the old path.
      count_next    = '0;
      drop_cnt_next = outstanding - CW'(rsp_fire);
    end else if (rsp_drop) begin
      drop_cnt_next = drop_cnt - CNT_ONE;
    end
  end

  // Control state: PCs, pointers, counters and the RUN/FLUSH state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      issue_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      if (i_PCSrc_F) begin
        issue_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (gnt_fire)
          issue_pc <= issue_pc + PC_STEP;
        if (push) begin
          rsp_pc <= rsp_pc + PC_STEP;
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop)
          rd_ptr <= rd_ptr + PTR_ONE;
      end
      count       <= count_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
      state       <= (drop_cnt_next != '0) ? FLUSH : RUN;
    end
  end

  // Buffer storage: write the accepted response at the tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= i_Mem_Rdata;
    end
  end

endmodule
